// File: rtl/adc_stream_pkg.sv
// Shared frame definitions for the ADC-to-UART streamer: header byte,
// frame length, frame FSM encoding and the checksum rule.
package adc_stream_pkg;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  // One state per frame byte plus IDLE.
  localparam int STATE_W = $clog2(FRAME_BYTES + 1);

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    HDR,
    MSB,
    LSB,
    CHK
  } frame_state_t;

  // Checksum byte: XOR of header, average MSB and average LSB.
  function automatic logic [7:0] frame_checksum(input logic [15:0] avg);
    return FRAME_HDR ^ avg[15:8] ^ avg[7:0];
  endfunction

endpackage

// File: rtl/uart_tx8n1.sv
// UART 8N1 byte serializer. One start bit, eight data bits LSB first,
// one stop bit, each lasting BAUD_DIV clocks. busy drops during the final
// clock of the stop bit so a byte written then follows with no idle gap.
module uart_tx8n1 #(
  parameter int BAUD_DIV = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wren,
  output logic       txd,
  output logic       busy
);

  localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       STOP_IDX  = 4'd9;

  logic             active;
  logic             txd_r;
  logic [8:0]       shreg;     // remaining data bits followed by the stop bit
  logic [3:0]       bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [CNT_W-1:0] baud_cnt;
  logic             bit_end;
  logic             last_tick;

  assign bit_end   = active && (baud_cnt == BAUD_LAST);
  assign last_tick = bit_end && (bit_idx == STOP_IDX);
  assign busy      = active && !last_tick;
  assign txd       = txd_r;

  // Bit timing and shifting; txd comes straight from a flop.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      txd_r    <= 1'b1;
      shreg    <= '1;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (wren && !busy) begin
      active   <= 1'b1;
      txd_r    <= 1'b0;
      shreg    <= {1'b1, din};
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (last_tick) begin
      active   <= 1'b0;
      txd_r    <= 1'b1;
      baud_cnt <= '0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      bit_idx  <= bit_idx + 4'd1;
      txd_r    <= shreg[0];
      shreg    <= {1'b1, shreg[8:1]};
    end else if (active) begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_uart_streamer.sv
// ADC sample averager feeding a result FIFO that is streamed out over a
// UART as 4-byte frames: A5, avg[15:8], avg[7:0], checksum.
module adc_uart_streamer
  import adc_stream_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int ACC_LOG2   = 4,
  parameter int BAUD_DIV   = 347,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_ain,
  output logic [15:0]       avg_out,
  output logic              avg_valid,
  output logic              txd,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  // ---------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------
  localparam int               ACC_W    = DATA_W + ACC_LOG2;
  localparam int               CNT_W    = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_sample;

  assign accept      = en && sample_valid && !restart;
  assign acc_sum     = acc + ACC_W'(data_ain);
  // With ACC_LOG2 = 0 the counter is stuck at 0 == CNT_LAST, so every
  // accepted sample completes a result.
  assign last_sample = (cnt == CNT_LAST);

  // Sum samples; on the last one of a block publish the average and
  // restart from zero so the next sample starts a fresh block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (restart) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last_sample) begin
          acc       <= '0;
          cnt       <= '0;
          avg_out   <= 16'(acc_sum >> ACC_LOG2);
          avg_valid <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  localparam int                FIFO_CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int                PTR_W         = FIFO_CW - 1;
  localparam logic [FIFO_CW-1:0] FIFO_FULL_CNT = FIFO_CW'(FIFO_DEPTH);

  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FIFO_CW-1:0] fifo_cnt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic               push_req;
  logic               do_push;
  logic               drop;

  // The result registered on the previous edge is pushed on this one.
  assign push_req   = avg_valid;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_req && (!fifo_full || fifo_pop);
  assign drop       = push_req && fifo_full && !fifo_pop;

  // Storage array.
  // NOTE: the memory array has no reset; only pointers and count need one,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= avg_out;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + FIFO_CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FIFO_CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky drop indication and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  frame_state_t state;
  frame_state_t state_next;
  logic [15:0]  frame_avg;
  logic [7:0]   tx_din;
  logic         tx_wren;
  logic         tx_busy;

  // State register, the frame's latched result and a registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      frame_avg <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (fifo_pop) frame_avg <= fifo_mem[rd_ptr];
    end
  end

  // Hand each byte to the serializer as soon as it can take it; leaving CHK
  // with data waiting starts the next frame in the same cycle.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    tx_wren    = 1'b0;
    tx_din     = FRAME_HDR;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          fifo_pop   = 1'b1;
          tx_wren    = 1'b1;
          state_next = HDR;
        end
      end
      HDR: begin
        if (!tx_busy) begin
          tx_wren    = 1'b1;
          tx_din     = frame_avg[15:8];
          state_next = MSB;
        end
      end
      MSB: begin
        if (!tx_busy) begin
          tx_wren    = 1'b1;
          tx_din     = frame_avg[7:0];
          state_next = LSB;
        end
      end
      LSB: begin
        if (!tx_busy) begin
          tx_wren    = 1'b1;
          tx_din     = frame_checksum(frame_avg);
          state_next = CHK;
        end
      end
      CHK: begin
        if (!tx_busy) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_wren    = 1'b1;
            state_next = HDR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk (clk),
    .rst (rst),
    .din (tx_din),
    .wren(tx_wren),
    .txd (txd),
    .busy(tx_busy)
  );

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Directed bench for adc_uart_streamer with three parameterisations:
//   a: ACC_LOG2=2, BAUD_DIV=4,   FIFO_DEPTH=8
//   b: ACC_LOG2=4, BAUD_DIV=4,   FIFO_DEPTH=8
//   c: ACC_LOG2=0, BAUD_DIV=347, FIFO_DEPTH=4
module tb_adc_uart_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        rst_a, en_a, restart_a, sv_a;
  logic [13:0] din_a;
  logic [15:0] avg_a;
  logic        avgv_a, txd_a, busy_a, ovf_a;
  logic [7:0]  drop_a;

  logic        rst_b, en_b, restart_b, sv_b;
  logic [13:0] din_b;
  logic [15:0] avg_b;
  logic        avgv_b, txd_b, busy_b, ovf_b;
  logic [7:0]  drop_b;

  logic        rst_c, en_c, restart_c, sv_c;
  logic [13:0] din_c;
  logic [15:0] avg_c;
  logic        avgv_c, txd_c, busy_c, ovf_c;
  logic [7:0]  drop_c;

  adc_uart_streamer #(.DATA_W(14), .ACC_LOG2(2), .BAUD_DIV(4), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .restart(restart_a), .sample_valid(sv_a),
    .data_ain(din_a), .avg_out(avg_a), .avg_valid(avgv_a), .txd(txd_a),
    .busy(busy_a), .overflow(ovf_a), .drop_cnt(drop_a));

  adc_uart_streamer #(.DATA_W(14), .ACC_LOG2(4), .BAUD_DIV(4), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .restart(restart_b), .sample_valid(sv_b),
    .data_ain(din_b), .avg_out(avg_b), .avg_valid(avgv_b), .txd(txd_b),
    .busy(busy_b), .overflow(ovf_b), .drop_cnt(drop_b));

  adc_uart_streamer #(.DATA_W(14), .ACC_LOG2(0), .BAUD_DIV(347), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .restart(restart_c), .sample_valid(sv_c),
    .data_ain(din_c), .avg_out(avg_c), .avg_valid(avgv_c), .txd(txd_c),
    .busy(busy_c), .overflow(ovf_c), .drop_cnt(drop_c));

  // Frame receiver results.
  logic [7:0] rx_bytes [32];
  int         n_rx;
  int         busy_len;
  int         framing_err;

  function automatic logic sig_txd(input int sel);
    case (sel)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic logic sig_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [15:0] sig_avg(input int sel);
    case (sel)
      0:       return avg_a;
      1:       return avg_b;
      default: return avg_c;
    endcase
  endfunction

  function automatic logic sig_avgv(input int sel);
    case (sel)
      0:       return avgv_a;
      1:       return avgv_b;
      default: return avgv_c;
    endcase
  endfunction

  function automatic logic sig_ovf(input int sel);
    case (sel)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic [7:0] sig_drop(input int sel);
    case (sel)
      0:       return drop_a;
      1:       return drop_b;
      default: return drop_c;
    endcase
  endfunction

  task automatic set_inputs(input int sel, input logic e, input logic rs,
                            input logic v, input logic [15:0] d);
    case (sel)
      0:       begin en_a = e; restart_a = rs; sv_a = v; din_a = d[13:0]; end
      1:       begin en_b = e; restart_b = rs; sv_b = v; din_b = d[13:0]; end
      default: begin en_c = e; restart_c = rs; sv_c = v; din_c = d[13:0]; end
    endcase
  endtask

  // Waits (bounded) for busy to rise, then samples txd at the middle of
  // every bit period while busy stays high. Bit positions are fixed relative
  // to the busy edge, so any gap or stretched bit shows up as a bad byte.
  task automatic capture(input int sel, input int baud, input int max_cycles);
    int         t;
    int         p;
    int         k;
    int         j;
    logic       b;
    logic [7:0] sh;
    n_rx        = 0;
    busy_len    = 0;
    framing_err = 0;
    sh          = '0;
    t           = 0;
    while (!sig_busy(sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!sig_busy(sel)) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_start[%0d]: busy still 0 after %0d cycles", sel, t);
      return;
    end
    while (sig_busy(sel) && busy_len < max_cycles) begin
      if (busy_len % baud == baud / 2) begin
        p = busy_len / baud;
        k = p / 10;
        j = p % 10;
        b = sig_txd(sel);
        if (j == 0) begin
          if (b !== 1'b0) framing_err++;
        end else if (j == 9) begin
          if (b !== 1'b1) framing_err++;
          if (k < 32) rx_bytes[k] = sh;
          n_rx = k + 1;
        end else begin
          sh[j-1] = b;
        end
      end
      busy_len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int s = 0; s < 3; s++) set_inputs(s, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (sig_txd(s) !== 1'b1) begin
        miscompares++; $display("FAIL reset_txd[%0d]: got %b want 1", s, sig_txd(s));
      end
      vectors++;
      if (sig_busy(s) !== 1'b0) begin
        miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", s, sig_busy(s));
      end
      vectors++;
      if (sig_avg(s) !== 16'h0) begin
        miscompares++; $display("FAIL reset_avg[%0d]: got %h want 0000", s, sig_avg(s));
      end
      vectors++;
      if (sig_avgv(s) !== 1'b0) begin
        miscompares++; $display("FAIL reset_avg_valid[%0d]: got %b want 0", s, sig_avgv(s));
      end
      vectors++;
      if (sig_ovf(s) !== 1'b0) begin
        miscompares++; $display("FAIL reset_overflow[%0d]: got %b want 0", s, sig_ovf(s));
      end
      vectors++;
      if (sig_drop(s) !== 8'h0) begin
        miscompares++; $display("FAIL reset_drop_cnt[%0d]: got %0d want 0", s, sig_drop(s));
      end
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (sig_txd(s) !== 1'b1 || sig_busy(s) !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle[%0d]: txd=%b busy=%b want txd=1 busy=0",
                 s, sig_txd(s), sig_busy(s));
      end
    end
  endtask

  // 100,200,300,400 -> 250 = 0x00FA, frame A5 00 FA 5F over 160 clocks.
  task automatic test_average_frame();
    logic [15:0] samples [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [7:0]  exp_b   [4] = '{8'hA5, 8'h00, 8'hFA, 8'h5F};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          set_inputs(0, 1'b1, 1'b0, 1'b1, samples[i]);
          @(negedge clk);
        end
        set_inputs(0, 1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (avgv_a !== 1'b1 || avg_a !== 16'h00FA) begin
          miscompares++;
          $display("FAIL avg_basic: avg_valid=%b avg_out=%h want 1/00fa", avgv_a, avg_a);
        end
        @(negedge clk);
        vectors++;
        if (avgv_a !== 1'b0) begin
          miscompares++; $display("FAIL avg_valid_pulse: got %b want 0", avgv_a);
        end
      end
      capture(0, 4, 400);
    join
    vectors++;
    if (n_rx !== 4 || framing_err !== 0) begin
      miscompares++;
      $display("FAIL basic_frame_shape: bytes=%0d framing_err=%0d want 4/0", n_rx, framing_err);
    end
    vectors++;
    if (busy_len !== 160) begin
      miscompares++; $display("FAIL basic_frame_len: got %0d clocks want 160", busy_len);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx_bytes[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL basic_frame_byte[%0d]: got %h want %h", i, rx_bytes[i], exp_b[i]);
      end
    end
  endtask

  // Sixteen full-scale 14-bit samples -> 0x3FFF, frame A5 3F FF 65.
  task automatic test_full_scale();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h3F, 8'hFF, 8'h65};
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          set_inputs(1, 1'b1, 1'b0, 1'b1, 16'h3FFF);
          @(negedge clk);
        end
        set_inputs(1, 1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (avgv_b !== 1'b1 || avg_b !== 16'h3FFF) begin
          miscompares++;
          $display("FAIL avg_full_scale: avg_valid=%b avg_out=%h want 1/3fff", avgv_b, avg_b);
        end
      end
      capture(1, 4, 400);
    join
    vectors++;
    if (n_rx !== 4 || framing_err !== 0 || busy_len !== 160) begin
      miscompares++;
      $display("FAIL full_scale_shape: bytes=%0d framing_err=%0d len=%0d want 4/0/160",
               n_rx, framing_err, busy_len);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx_bytes[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL full_scale_byte[%0d]: got %h want %h", i, rx_bytes[i], exp_b[i]);
      end
    end
  endtask

  // Three samples, a restart cycle carrying a sample, then 8,8,8,8 with
  // en=0 and sample_valid=0 cycles interleaved -> average 8, frame A5 00 08 AD.
  task automatic test_restart();
    logic [2:0]  flags [11] = '{3'b101, 3'b101, 3'b101, 3'b111, 3'b101, 3'b001,
                                3'b101, 3'b100, 3'b101, 3'b101, 3'b000};
    logic [15:0] data  [11] = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd8,
                                16'd5000, 16'd8, 16'd3000, 16'd8, 16'd8, 16'd0};
    logic [7:0]  exp_b [4]  = '{8'hA5, 8'h00, 8'h08, 8'hAD};
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          set_inputs(0, flags[i][2], flags[i][1], flags[i][0], data[i]);
          @(negedge clk);
          if (i < 9) begin
            vectors++;
            if (avgv_a !== 1'b0) begin
              miscompares++; $display("FAIL restart_early_valid[%0d]: got 1 want 0", i);
            end
          end
        end
        set_inputs(0, flags[10][2], flags[10][1], flags[10][0], data[10]);
        vectors++;
        if (avgv_a !== 1'b1 || avg_a !== 16'h0008) begin
          miscompares++;
          $display("FAIL restart_avg: avg_valid=%b avg_out=%h want 1/0008", avgv_a, avg_a);
        end
      end
      capture(0, 4, 400);
    join
    vectors++;
    if (n_rx !== 4 || framing_err !== 0 || busy_len !== 160) begin
      miscompares++;
      $display("FAIL restart_frame_shape: bytes=%0d framing_err=%0d len=%0d want 4/0/160",
               n_rx, framing_err, busy_len);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx_bytes[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL restart_frame_byte[%0d]: got %h want %h", i, rx_bytes[i], exp_b[i]);
      end
    end
  endtask

  // Two results queued -> two frames back to back, 320 clocks of busy.
  task automatic test_back_to_back();
    logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h10, 8'hB5, 8'hA5, 8'h12, 8'h34, 8'h83};
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          set_inputs(0, 1'b1, 1'b0, 1'b1, (i < 4) ? 16'h0010 : 16'h1234);
          @(negedge clk);
        end
        set_inputs(0, 1'b0, 1'b0, 1'b0, 16'h0);
      end
      capture(0, 4, 800);
    join
    vectors++;
    if (n_rx !== 8 || framing_err !== 0) begin
      miscompares++;
      $display("FAIL b2b_shape: bytes=%0d framing_err=%0d want 8/0", n_rx, framing_err);
    end
    vectors++;
    if (busy_len !== 320) begin
      miscompares++; $display("FAIL b2b_len: got %0d clocks want 320", busy_len);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rx_bytes[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, rx_bytes[i], exp_b[i]);
      end
    end
  endtask

  // Two results queued, reset during the LSB byte (0x32) of the first frame.
  task automatic test_reset_mid_frame();
    int busy_seen;
    int low_seen;
    int t;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          set_inputs(0, 1'b1, 1'b0, 1'b1, (i < 4) ? 16'd50 : 16'd60);
          @(negedge clk);
        end
        set_inputs(0, 1'b0, 1'b0, 1'b0, 16'h0);
      end
      begin
        t = 0;
        while (!busy_a && t < 100) begin
          @(negedge clk);
          t++;
        end
        // Index 93 falls in data bit 2 of the LSB byte 0x32, which is 0.
        repeat (93) @(negedge clk);
      end
    join
    vectors++;
    if (busy_a !== 1'b1 || txd_a !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_lsb_state: busy=%b txd=%b want 1/0", busy_a, txd_a);
    end
    rst_a = 1'b1;
    #1;
    vectors++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: txd=%b busy=%b want 1/0", txd_a, busy_a);
    end
    vectors++;
    if (avg_a !== 16'h0 || avgv_a !== 1'b0 || ovf_a !== 1'b0 || drop_a !== 8'h0) begin
      miscompares++;
      $display("FAIL async_reset_regs: avg=%h valid=%b ovf=%b drop=%0d want 0/0/0/0",
               avg_a, avgv_a, ovf_a, drop_a);
    end
    @(negedge clk);
    rst_a     = 1'b0;
    busy_seen = 0;
    low_seen  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen++;
      if (txd_a !== 1'b1) low_seen++;
    end
    vectors++;
    if (busy_seen !== 0 || low_seen !== 0) begin
      miscompares++;
      $display("FAIL no_frame_after_reset: busy cycles=%0d txd-low cycles=%0d want 0/0",
               busy_seen, low_seen);
    end
  endtask

  // ACC_LOG2=0, FIFO_DEPTH=4: 20 samples -> 1 popped, 4 held, 15 dropped.
  task automatic test_overflow();
    logic [7:0] exp_chk [5] = '{8'hC1, 8'hC0, 8'hC3, 8'hC2, 8'hCD};
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          set_inputs(2, 1'b1, 1'b0, 1'b1, 16'(100 + i));
          @(negedge clk);
        end
        set_inputs(2, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (ovf_c !== 1'b1) begin
          miscompares++; $display("FAIL overflow_flag: got %b want 1", ovf_c);
        end
        vectors++;
        if (drop_c !== 8'd15) begin
          miscompares++; $display("FAIL drop_cnt: got %0d want 15", drop_c);
        end
      end
      capture(2, 347, 80000);
    join
    vectors++;
    if (n_rx !== 20 || framing_err !== 0 || busy_len !== 69400) begin
      miscompares++;
      $display("FAIL overflow_frames_shape: bytes=%0d framing_err=%0d len=%0d want 20/0/69400",
               n_rx, framing_err, busy_len);
    end
    for (int f = 0; f < 5; f++) begin
      vectors++;
      if (rx_bytes[4*f] !== 8'hA5 || rx_bytes[4*f+1] !== 8'h00 ||
          rx_bytes[4*f+2] !== 8'(100 + f) || rx_bytes[4*f+3] !== exp_chk[f]) begin
        miscompares++;
        $display("FAIL overflow_frame[%0d]: got %h %h %h %h want a5 00 %h %h", f,
                 rx_bytes[4*f], rx_bytes[4*f+1], rx_bytes[4*f+2], rx_bytes[4*f+3],
                 8'(100 + f), exp_chk[f]);
      end
    end
    vectors++;
    if (ovf_c !== 1'b1 || drop_c !== 8'd15) begin
      miscompares++;
      $display("FAIL overflow_sticky: ovf=%b drop=%0d want 1/15", ovf_c, drop_c);
    end
  endtask

  initial begin
    test_reset();
    test_average_frame();
    test_full_scale();
    test_restart();
    test_back_to_back();
    test_reset_mid_frame();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_uart_streamer.md
ADC_UART_STREAMER -- requirements
Module: adc_uart_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 14: ADC sample width, 1..16.
REQ-002 SHALL have parameter ACC_LOG2, default 4: log2 of the samples averaged per result, 0..8.
REQ-003 SHALL have parameter BAUD_DIV, default 347: clocks per UART bit, at least 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: result FIFO entries, a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: sampling enable.
REQ-008 SHALL have port restart, input, 1 bit: synchronous clear of the accumulator.
REQ-009 SHALL have port sample_valid, input, 1 bit: data_ain is valid this cycle.
REQ-010 SHALL have port data_ain, input, DATA_W bits: unsigned ADC sample.
REQ-011 SHALL have port avg_out, output, 16 bits: last completed average, zero-extended.
REQ-012 SHALL have port avg_valid, output, 1 bit: one-cycle pulse when avg_out updates.
REQ-013 SHALL have port txd, output, 1 bit: UART 8N1 serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit: high while a frame is being transmitted.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, set when a result is dropped.
REQ-016 SHALL have port drop_cnt, output, 8 bits: count of dropped results, saturating at 255.

Function
REQ-017 SHALL accept a sample on each cycle with en=1, sample_valid=1 and restart=0.
REQ-018 SHALL use an accumulator DATA_W+ACC_LOG2 bits wide and a sample counter ACC_LOG2 bits wide; with ACC_LOG2=0 every accepted sample is itself a result.
REQ-019 SHALL, on the 2^ACC_LOG2-th accepted sample, register avg_out = (acc + sample) >> ACC_LOG2, pulse avg_valid and push the result into the FIFO one cycle after that sample; the accumulator restarts from 0 with no lost sample.
REQ-020 SHALL, on restart=1, clear the accumulator and counter on the next edge and ignore that cycle's sample; FIFO contents and any in-flight frame are unaffected.
REQ-021 SHALL, with en=0, hold the accumulator and counter; the transmit path keeps running.
REQ-022 SHALL drop a push when the FIFO is full and no pop occurs that cycle; each drop sets overflow and increments drop_cnt.
REQ-023 SHALL accept both operations without overflow when a push and a pop occur in the same cycle while the FIFO is full.
REQ-024 SHALL give the frame FSM the states IDLE, HDR, MSB, LSB, CHK.
REQ-025 SHALL, in IDLE with the FIFO non-empty, pop one entry, latch it and go to HDR; busy rises on the same edge.
REQ-026 SHALL send one byte per state in the order HDR=0xA5, MSB=avg[15:8], LSB=avg[7:0], CHK=XOR of the three preceding bytes, then return to IDLE.
REQ-027 SHALL frame each byte as a start bit 0, 8 data bits LSB-first and a stop bit 1, each bit lasting exactly BAUD_DIV clocks.
REQ-028 SHALL make a frame exactly 40*BAUD_DIV clocks long.
REQ-029 SHALL start the next frame immediately after the CHK stop bit when the FIFO is non-empty, with no idle gap and busy staying high.
REQ-030 SHALL drive txd from a register, so it never glitches.

Reset
REQ-031 SHALL, while rst=1, immediately force txd=1, busy=0, avg_out=0, avg_valid=0, overflow=0 and drop_cnt=0, empty the FIFO, clear the accumulator and counter, and put the FSM in IDLE.
REQ-032 SHALL abort a frame interrupted by reset; it is not resumed.
REQ-033 SHALL clear overflow and drop_cnt only by reset.

Structure
REQ-034 SHALL place FRAME_HDR=8'hA5, FRAME_BYTES=4 and the frame-state encoding in the shared package adc_stream_pkg.
REQ-035 SHALL implement the byte serializer as one sub-module, uart_tx8n1 (ports: clk, rst, din[7:0], wren, txd, busy; parameter BAUD_DIV).
REQ-036 SHALL implement the FIFO and the accumulator inline.

Verification
REQ-037 SHALL cover: ACC_LOG2=2, BAUD_DIV=4, samples 100, 200, 300, 400 -> avg_out=0x00FA, txd frame A5 00 FA 5F, 160 clocks, busy high throughout.
REQ-038 SHALL cover: DATA_W=14, ACC_LOG2=4, sixteen samples of 0x3FFF -> avg_out=0x3FFF, frame A5 3F FF 65.
REQ-039 SHALL cover: ACC_LOG2=0, FIFO_DEPTH=4, BAUD_DIV=347, 20 consecutive valid samples -> 1 entry popped, 4 held, 15 dropped: overflow=1, drop_cnt=15; the 5 frames received are samples 0..4.
REQ-040 SHALL cover: ACC_LOG2=2, restart after 3 samples, then samples 8, 8, 8, 8 -> avg_out=8, the first 3 samples excluded.
REQ-041 SHALL cover: rst asserted mid-LSB byte -> txd=1 and busy=0 before the next clock edge, FIFO empty, no further frame.
REQ-042 SHALL cover: two results queued, BAUD_DIV=4 -> second frame's start bit immediately follows the first frame's CHK stop bit, 320 clocks total.
